alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have in_valid (input, 1) and in_ready (output, 1): the instruction-accept handshake.
REQ-005 SHALL have instr (input, 32): the instruction word; opcode is [31:26], funct is [5:0], immediate is [15:0].
REQ-006 SHALL have rs_data and rt_data (inputs, 32 each, signed): the register operands.
REQ-007 SHALL have alu_op (output, 4), alu_a (output, 32) and alu_b (output, 32): the registered drive to the ALU.
REQ-008 SHALL have alu_result (input, 32) and alu_zero (input, 1): the combinational ALU return.
REQ-009 SHALL have out_valid (output, 1) and out_ready (input, 1): the result handshake.
REQ-010 SHALL have out_result (output, 32), out_zero (output, 1), out_branch (output, 1), out_illegal (output, 1) and retired (output, CNT_W).

Function
REQ-011 SHALL use three states:
- IDLE: in_ready=1.
- EXEC: ALU evaluating.
- DONE: out_valid=1.
REQ-012 SHALL in IDLE, when in_valid=1, accept at that edge: register the decoded alu_op, alu_a and alu_b, and go to EXEC.
REQ-013 SHALL in EXEC capture alu_result and alu_zero into out_result/out_zero at the next edge, compute out_branch, and go to DONE; latency from accept edge to out_valid=1 is exactly 2 edges.
REQ-014 SHALL in DONE hold all out_* stable while out_ready=0; when out_ready=1, return to IDLE at that edge and increment retired.
REQ-015 SHALL keep in_ready=0 in EXEC and DONE; throughput is one instruction per 3 cycles at best.
REQ-016 SHALL decode R-type (opcode 000000) funct codes as follows, with alu_a=rs_data and alu_b=rt_data:
- 100100 -> 0000 (and)
- 100101 -> 0001 (or)
- 100000 -> 0010 (add)
- 100010 -> 0110 (sub)
- 101010 -> 0111 (slt)
- 100111 -> 1100 (nor)
REQ-017 SHALL decode I-type opcodes as follows, with alu_a=rs_data and alu_b=imm:
- 100011 lw, 101011 sw, 001000 addi -> 0010, sign-extended imm.
- 001010 slti -> 0111, sign-extended imm.
- 001100 andi -> 0000, zero-extended imm.
- 001101 ori -> 0001, zero-extended imm.
REQ-018 SHALL decode opcode 000100 (beq) as 0110 with alu_b=rt_data, and set out_branch=alu_zero at capture; out_branch=0 for all other instructions.
REQ-019 SHALL treat any other opcode/funct as illegal: alu_op=1111, alu_a=0, alu_b=0, out_illegal=1 at capture; the instruction still completes the handshake and counts as retired.
REQ-020 SHALL wrap retired from all-ones to 0 with no flag.
REQ-021 SHALL ignore in_valid outside IDLE and ignore out_ready outside DONE.

Reset
REQ-022 SHALL on rst_n=0 immediately (asynchronously) force state=IDLE and all outputs to 0 except in_ready, which is 1 in IDLE after reset.
REQ-023 SHALL discard an in-flight instruction on reset mid-EXEC or mid-DONE: no out_valid is produced and retired is not incremented.
REQ-024 SHALL first accept on the first rising edge with rst_n=1 and in_valid=1.

Structure
REQ-025 SHALL place in shared package alu_pkg:
- The 4-bit ALU operation codes (AND, OR, ADD, SUB, SLT, NOR, ILLEGAL=1111).
- The opcode and funct constants.
- The state enumeration.
REQ-026 SHALL implement decoding in one combinational sub-module alu_decode (instr -> alu_op, imm-select, sign/zero-extend select, is_branch, illegal), instantiated once.

Verification
REQ-027 SHALL check R-type add: rs=5, rt=7, funct 100000 -> alu_op=0010; out_valid 2 edges after accept; out_result=12, out_zero=0.
REQ-028 SHALL check beq: rs=rt=0x1234 -> alu_op=0110, out_zero=1, out_branch=1; with rt=0x1235 -> out_branch=0.
REQ-029 SHALL check immediates: slti rs=-3, imm=0xFFFE -> out_result=1; andi rs=0xFFFFFFFF, imm=0x8001 -> alu_b=0x00008001.
REQ-030 SHALL check backpressure: out_ready=0 for 5 cycles -> out_valid and out_result held, in_ready=0, retired unchanged; out_ready=1 -> IDLE next edge, retired+1.
REQ-031 SHALL check illegal instruction: funct 111111 -> alu_op=1111, out_illegal=1, out_result=0; counter with CNT_W=4 wraps 15 -> 0 after 16 retirements.
REQ-032 SHALL check reset: rst_n low during EXEC -> outputs 0 without a clock edge; after release, in_ready=1, retired=0, and no stale out_valid.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared constants for the ALU issue stage.
//                - 4-bit ALU operation codes
//                - instruction opcode / funct field values
//                - issue-stage state encoding
//                - immediate extension helper
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // ALU operation codes driven on alu_op
    localparam logic [3:0] ALU_AND     = 4'b0000;
    localparam logic [3:0] ALU_OR      = 4'b0001;
    localparam logic [3:0] ALU_ADD     = 4'b0010;
    localparam logic [3:0] ALU_SUB     = 4'b0110;
    localparam logic [3:0] ALU_SLT     = 4'b0111;
    localparam logic [3:0] ALU_NOR     = 4'b1100;
    localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

    // Opcode field instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // Funct field instr[5:0] for R-type
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // Issue-stage states; IDLE is all-zero so reset lands there directly
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_EXEC = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // 16-bit immediate to 32 bits, sign- or zero-extended
    function automatic logic [31:0] ext_imm(input logic [15:0] imm, input logic sext);
        return sext ? {{16{imm[15]}}, imm} : {16'h0000, imm};
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_decode.sv
`default_nettype none
// ============================================================================
//  Module      : alu_decode
//  Description : Combinational instruction decoder for the ALU issue stage.
//  Ports       : instr_i      - 32-bit instruction word
//                alu_op_o     - 4-bit ALU operation
//                imm_sel_o    - 1: operand B is the immediate, 0: rt_data
//                sext_o       - 1: sign-extend immediate, 0: zero-extend
//                is_branch_o  - instruction is beq
//                illegal_o    - opcode/funct not recognised
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [3:0]  alu_op_o,
    output logic        imm_sel_o,
    output logic        sext_o,
    output logic        is_branch_o,
    output logic        illegal_o
);

    logic [5:0] w_opcode;
    logic [5:0] w_funct;
    logic       w_unused_fields;

    assign w_opcode        = instr_i[31:26];
    assign w_funct         = instr_i[5:0];
    // Register specifiers and immediate are consumed by the issue stage
    assign w_unused_fields = ^instr_i[25:6];

    // Everything defaults to illegal; each recognised encoding clears it
    always_comb begin
        alu_op_o    = ALU_ILLEGAL;
        imm_sel_o   = 1'b0;
        sext_o      = 1'b0;
        is_branch_o = 1'b0;
        illegal_o   = 1'b1;
        case (w_opcode)
            OP_RTYPE: begin
                illegal_o = 1'b0;
                case (w_funct)
                    FN_AND:  alu_op_o = ALU_AND;
                    FN_OR:   alu_op_o = ALU_OR;
                    FN_ADD:  alu_op_o = ALU_ADD;
                    FN_SUB:  alu_op_o = ALU_SUB;
                    FN_SLT:  alu_op_o = ALU_SLT;
                    FN_NOR:  alu_op_o = ALU_NOR;
                    default: illegal_o = 1'b1;
                endcase
            end
            OP_LW, OP_SW, OP_ADDI: begin
                alu_op_o  = ALU_ADD;
                imm_sel_o = 1'b1;
                sext_o    = 1'b1;
                illegal_o = 1'b0;
            end
            OP_SLTI: begin
                alu_op_o  = ALU_SLT;
                imm_sel_o = 1'b1;
                sext_o    = 1'b1;
                illegal_o = 1'b0;
            end
            OP_ANDI: begin
                alu_op_o  = ALU_AND;
                imm_sel_o = 1'b1;
                illegal_o = 1'b0;
            end
            OP_ORI: begin
                alu_op_o  = ALU_OR;
                imm_sel_o = 1'b1;
                illegal_o = 1'b0;
            end
            OP_BEQ: begin
                alu_op_o    = ALU_SUB;
                is_branch_o = 1'b1;
                illegal_o   = 1'b0;
            end
            default: ;
        endcase
    end

endmodule : alu_decode
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue
//  Description : Single-entry ALU issue stage. Accepts one instruction,
//                drives a registered operation to an external combinational
//                ALU, captures its result and offers it on a valid/ready
//                output handshake. Counts retired instructions.
//  Ports       : clk, rst_n             - clock, async active-low reset
//                in_valid/in_ready      - instruction accept handshake
//                instr, rs_data, rt_data- instruction and operands
//                alu_op/alu_a/alu_b     - registered ALU drive
//                alu_result/alu_zero    - combinational ALU return
//                out_valid/out_ready    - result handshake
//                out_result, out_zero, out_branch, out_illegal - result
//                retired                - wrapping retired-instruction count
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_issue
    import alu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         instr,
    input  logic signed [31:0]  rs_data,
    input  logic signed [31:0]  rt_data,
    output logic [3:0]          alu_op,
    output logic [31:0]         alu_a,
    output logic [31:0]         alu_b,
    input  logic [31:0]         alu_result,
    input  logic                alu_zero,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_result,
    output logic                out_zero,
    output logic                out_branch,
    output logic                out_illegal,
    output logic [CNT_W-1:0]    retired
);

    state_t            state_q, state_d;
    logic [3:0]        alu_op_q;
    logic [31:0]       alu_a_q, alu_b_q;
    logic              branch_q, illegal_q;
    logic [31:0]       out_result_q;
    logic              out_zero_q, out_branch_q, out_illegal_q;
    logic [CNT_W-1:0]  retired_q;

    logic [3:0]        w_dec_op;
    logic              w_imm_sel, w_sext, w_is_branch, w_illegal;
    logic [31:0]       w_a_dec, w_b_dec;
    logic              w_accept, w_capture, w_retire;

    alu_decode u_decode (
        .instr_i     (instr),
        .alu_op_o    (w_dec_op),
        .imm_sel_o   (w_imm_sel),
        .sext_o      (w_sext),
        .is_branch_o (w_is_branch),
        .illegal_o   (w_illegal)
    );

    // Illegal instructions present zero operands so the ALU sees no stale data
    assign w_a_dec = w_illegal ? 32'h0 : rs_data;
    assign w_b_dec = w_illegal ? 32'h0 :
                     (w_imm_sel ? ext_imm(instr[15:0], w_sext) : rt_data);

    assign w_accept  = (state_q == ST_IDLE) && in_valid;
    assign w_capture = (state_q == ST_EXEC);
    assign w_retire  = (state_q == ST_DONE) && out_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid)  state_d = ST_EXEC;
            ST_EXEC:                state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            alu_op_q      <= 4'h0;
            alu_a_q       <= 32'h0;
            alu_b_q       <= 32'h0;
            branch_q      <= 1'b0;
            illegal_q     <= 1'b0;
            out_result_q  <= 32'h0;
            out_zero_q    <= 1'b0;
            out_branch_q  <= 1'b0;
            out_illegal_q <= 1'b0;
            retired_q     <= '0;
        end else begin
            state_q <= state_d;
            if (w_accept) begin
                alu_op_q  <= w_dec_op;
                alu_a_q   <= w_a_dec;
                alu_b_q   <= w_b_dec;
                branch_q  <= w_is_branch;
                illegal_q <= w_illegal;
            end
            if (w_capture) begin
                out_result_q  <= alu_result;
                out_zero_q    <= alu_zero;
                out_branch_q  <= branch_q & alu_zero;
                out_illegal_q <= illegal_q;
            end
            // Natural wrap from all-ones to zero
            if (w_retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    assign in_ready    = (state_q == ST_IDLE);
    assign out_valid   = (state_q == ST_DONE);
    assign alu_op      = alu_op_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign out_result  = out_result_q;
    assign out_zero    = out_zero_q;
    assign out_branch  = out_branch_q;
    assign out_illegal = out_illegal_q;
    assign retired     = retired_q;

endmodule : alu_issue
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_issue
//  Description : Self-checking bench for alu_issue. Provides a behavioural
//                ALU, a transaction-level reference model, directed cases
//                with literal expectations and a randomized phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue;

    localparam int CNT_W = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [31:0]        instr = 32'h0;
    logic signed [31:0] rs_data = 32'sh0;
    logic signed [31:0] rt_data = 32'sh0;
    logic [3:0]         alu_op;
    logic [31:0]        alu_a, alu_b;
    logic [31:0]        alu_result;
    logic               alu_zero;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [31:0]        out_result;
    logic               out_zero, out_branch, out_illegal;
    logic [CNT_W-1:0]   retired;

    int n_cmp = 0;
    int n_err = 0;
    int d_ret = 0;

    always #5 clk = ~clk;

    alu_issue #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .alu_op      (alu_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_zero    (out_zero),
        .out_branch  (out_branch),
        .out_illegal (out_illegal),
        .retired     (retired)
    );

    // ---------------- behavioural ALU ----------------
    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1100: return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    always_comb begin
        alu_result = alu_fn(alu_op, alu_a, alu_b);
        alu_zero   = (alu_result == 32'd0);
    end

    // ---------------- reference decode ----------------
    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        br;
        logic        ill;
    } exp_t;

    function automatic exp_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic br);
        exp_t e;
        e.op = op; e.a = a; e.b = b; e.br = br; e.ill = 1'b0;
        return e;
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        exp_t        e;
        logic [31:0] simm, zimm;
        simm = {{16{ins[15]}}, ins[15:0]};
        zimm = {16'h0000, ins[15:0]};
        e.op = 4'b1111; e.a = 32'h0; e.b = 32'h0; e.br = 1'b0; e.ill = 1'b1;
        case (ins[31:26])
            6'b000000: case (ins[5:0])
                6'b100100: e = mk(4'b0000, rs, rt, 1'b0);
                6'b100101: e = mk(4'b0001, rs, rt, 1'b0);
                6'b100000: e = mk(4'b0010, rs, rt, 1'b0);
                6'b100010: e = mk(4'b0110, rs, rt, 1'b0);
                6'b101010: e = mk(4'b0111, rs, rt, 1'b0);
                6'b100111: e = mk(4'b1100, rs, rt, 1'b0);
                default: ;
            endcase
            6'b100011, 6'b101011, 6'b001000: e = mk(4'b0010, rs, simm, 1'b0);
            6'b001010: e = mk(4'b0111, rs, simm, 1'b0);
            6'b001100: e = mk(4'b0000, rs, zimm, 1'b0);
            6'b001101: e = mk(4'b0001, rs, zimm, 1'b0);
            6'b000100: e = mk(4'b0110, rs, rt, 1'b1);
            default: ;
        endcase
        return e;
    endfunction

    // ---------------- transaction model ----------------
    // m_age counts edges since the accepting edge; result is offered from 1 on
    logic             m_busy = 1'b0;
    int               m_age = 0;
    exp_t             m_exp;
    logic [CNT_W-1:0] m_retired = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy    <= 1'b0;
            m_age     <= 0;
            m_retired <= '0;
        end else if (m_busy) begin
            if (m_age >= 1 && out_ready) begin
                m_busy    <= 1'b0;
                m_retired <= m_retired + 1'b1;
            end else begin
                m_age <= 1;
            end
        end else if (in_valid) begin
            m_busy <= 1'b1;
            m_age  <= 0;
            m_exp  <= ref_decode(instr, rs_data, rt_data);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_in_ready", in_ready, !m_busy);
            chk("m_out_valid", out_valid, m_busy && m_age >= 1);
            chk("m_retired", retired, m_retired);
            if (m_busy) begin
                chk("m_alu_op", alu_op, m_exp.op);
                chk("m_alu_a", alu_a, m_exp.a);
                chk("m_alu_b", alu_b, m_exp.b);
            end
            if (m_busy && m_age >= 1) begin
                chk("m_out_result", out_result, alu_fn(m_exp.op, m_exp.a, m_exp.b));
                chk("m_out_zero", out_zero, alu_fn(m_exp.op, m_exp.a, m_exp.b) == 32'd0);
                chk("m_out_branch", out_branch, m_exp.br && (alu_fn(m_exp.op, m_exp.a, m_exp.b) == 32'd0));
                chk("m_out_illegal", out_illegal, m_exp.ill);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [31:0] rtype(input logic [5:0] fn);
        return {6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] opc, input logic [15:0] imm);
        return {opc, 5'd1, 5'd2, imm};
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("wait_in_ready", in_ready, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        d_ret = 0;
    endtask

    // Issue one instruction and check literal expectations through retirement
    task automatic directed(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                            input logic [3:0] eop, input logic [31:0] eb, input logic [31:0] eres,
                            input logic ez, input logic ebr, input logic eill, input int hold);
        wait_ready();
        instr = ins; rs_data = rs; rt_data = rt; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("d_alu_op", alu_op, eop);
        chk("d_alu_b", alu_b, eb);
        chk("d_valid_exec", out_valid, 0);
        @(negedge clk);
        chk("d_valid_done", out_valid, 1);
        chk("d_result", out_result, eres);
        chk("d_zero", out_zero, ez);
        chk("d_branch", out_branch, ebr);
        chk("d_illegal", out_illegal, eill);
        repeat (hold) begin
            @(negedge clk);
            chk("d_hold_valid", out_valid, 1);
            chk("d_hold_result", out_result, eres);
            chk("d_hold_in_ready", in_ready, 0);
            chk("d_hold_retired", retired, d_ret % 16);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        d_ret++;
        chk("d_back_idle", in_ready, 1);
        chk("d_valid_clear", out_valid, 0);
        chk("d_retired", retired, d_ret % 16);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0]  fns [6];
        logic [31:0] r;
        fns[0] = 6'b100100; fns[1] = 6'b100101; fns[2] = 6'b100000;
        fns[3] = 6'b100010; fns[4] = 6'b101010; fns[5] = 6'b100111;
        r = $urandom;
        case ($urandom_range(0, 9))
            0: r = {6'b000000, r[25:6], fns[$urandom_range(0, 5)]};
            1: r = {6'b100011, r[25:0]};
            2: r = {6'b101011, r[25:0]};
            3: r = {6'b001000, r[25:0]};
            4: r = {6'b001010, r[25:0]};
            5: r = {6'b001100, r[25:0]};
            6: r = {6'b001101, r[25:0]};
            7, 8: r = {6'b000100, r[25:0]};
            default: ;
        endcase
        return r;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // add 5+7
        directed(rtype(6'b100000), 32'd5, 32'd7, 4'b0010, 32'd7, 32'd12, 1'b0, 1'b0, 1'b0, 0);
        // beq taken / not taken
        directed(itype(6'b000100, 16'h0003), 32'h1234, 32'h1234, 4'b0110, 32'h1234, 32'h0, 1'b1, 1'b1, 1'b0, 0);
        directed(itype(6'b000100, 16'h0003), 32'h1234, 32'h1235, 4'b0110, 32'h1235, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 0);
        // slti -3 < -2
        directed(itype(6'b001010, 16'hFFFE), 32'hFFFFFFFD, 32'h0, 4'b0111, 32'hFFFFFFFE, 32'd1, 1'b0, 1'b0, 1'b0, 0);
        // andi zero-extends
        directed(itype(6'b001100, 16'h8001), 32'hFFFFFFFF, 32'h0, 4'b0000, 32'h00008001, 32'h00008001, 1'b0, 1'b0, 1'b0, 0);
        // lw sign-extends, ori zero-extends
        directed(itype(6'b100011, 16'h8000), 32'h00010000, 32'h0, 4'b0010, 32'hFFFF8000, 32'h00008000, 1'b0, 1'b0, 1'b0, 0);
        directed(itype(6'b001101, 16'h8000), 32'h00000001, 32'h0, 4'b0001, 32'h00008000, 32'h00008001, 1'b0, 1'b0, 1'b0, 0);
        // illegal funct
        directed(rtype(6'b111111), 32'h55, 32'h66, 4'b1111, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 0);
        // backpressure for 5 cycles
        directed(rtype(6'b100010), 32'd20, 32'd3, 4'b0110, 32'd3, 32'd17, 1'b0, 1'b0, 1'b0, 5);

        // asynchronous reset in the middle of EXEC
        wait_ready();
        instr = rtype(6'b100000); rs_data = 32'sd9; rt_data = 32'sd1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("r_alu_op", alu_op, 0);
        chk("r_alu_a", alu_a, 0);
        chk("r_alu_b", alu_b, 0);
        chk("r_out_valid", out_valid, 0);
        chk("r_out_result", out_result, 0);
        chk("r_retired", retired, 0);
        chk("r_in_ready", in_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("r_post_in_ready", in_ready, 1);
            chk("r_post_valid", out_valid, 0);
            chk("r_post_retired", retired, 0);
        end

        // accept on the very first edge after reset release
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        instr = rtype(6'b100000); rs_data = 32'sd5; rt_data = 32'sd7; in_valid = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("f_in_ready", in_ready, 0);
        chk("f_alu_op", alu_op, 4'b0010);
        @(negedge clk);
        chk("f_valid", out_valid, 1);
        chk("f_result", out_result, 32'd12);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("f_retired", retired, 1);

        // retired counter wrap after 16 retirements
        do_reset();
        for (int i = 0; i < 16; i++) begin
            directed(rtype(6'b111111), 32'h1, 32'h2, 4'b1111, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 0);
        end
        chk("wrap_zero", retired, 0);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 1) == 1);
            instr     = rand_instr();
            rs_data   = $urandom;
            rt_data   = ($urandom_range(0, 1) == 1) ? rs_data : $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule : tb_alu_issue
`default_nettype wire
